tick_monitor: RTL and testbench
===============================

Name: tick_monitor

Overview:
- Receive-side checker for the millisecond tick interface driven by the counter block (single-cycle tick pulse plus a flip level that toggles once per tick).
- Measures the clock-cycle interval between ticks, locks when ticks arrive inside a tolerance window, and flags early, late and flip-mismatch errors.
- Keeps a 4-bit tick count that mirrors the transmitter's counter.
- Sits beside the counter in the lab top level and provides self-check status to benches and LEDs.

Parameters:
- TICK_PERIOD, 100, nominal clocks between tick pulses.
- TOL, 2, allowed deviation in clocks (window is TICK_PERIOD-TOL to TICK_PERIOD+TOL inclusive).
- PW, 16, width of the interval counter and the period output; must satisfy TICK_PERIOD+TOL < 2^PW.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  tick pulse from the transmitter; rising edge counts as one tick.
- flip_in  input  1  level that toggles once per tick.
- tick_count  output  4  ticks received mod 16.
- period  output  PW  last measured interval in clocks.
- locked  output  1  high only in the LOCKED state.
- err_early  output  1  one-cycle pulse.
- err_late  output  1  one-cycle pulse.
- err_flip  output  1  one-cycle pulse.
- err_count  output  8  saturating total of error pulses.

Behaviour:
- Clock and reset:
  - One clock, clk. reset is synchronous and active-high.
  - At the first clk edge with reset=1, all outputs go to 0, state goes to IDLE, gap counter g=0, and the expected flip register takes the current flip_in.
  - Reset asserted mid-operation has the same effect on the next edge. No pulse from pre-reset activity may appear after reset.
- Edge detection:
  - tick_q is tick registered. A tick event is tick & ~tick_q.
  - A tick held high for several cycles counts once.
- Gap counter g:
  - Held at 0 in IDLE.
  - Cleared to 0 in any cycle with a tick event.
  - Otherwise increments, saturating at 2^PW-1.
  - The measured interval of a tick event is P = g+1. Ticks at cycles n and n+100 give P=100.
- Per tick event (not in IDLE):
  - period <= P on the next edge.
  - tick_count increments on every tick event in every state, including IDLE, wrapping 15 -> 0.
- Window and timeout:
  - A tick is in-window when TICK_PERIOD-TOL <= P <= TICK_PERIOD+TOL. It is early when P < TICK_PERIOD-TOL.
  - Timeout occurs in a cycle with no tick event where g+1 == TICK_PERIOD+TOL, in the SYNC or LOCKED state. A tick event in that same cycle is in-window; the tick wins.
- State machine:
  - IDLE -> SYNC on a tick event.
  - SYNC:
    - In-window tick -> LOCKED.
    - Early tick -> stay in SYNC, raise err_early; g restarts from this tick.
    - Timeout -> IDLE, raise err_late.
  - LOCKED:
    - In-window tick -> stay in LOCKED.
    - Early tick -> LOST, raise err_early.
    - Timeout -> LOST, raise err_late.
  - LOST: tick event -> SYNC, with no window check and no error. g counts but there is no timeout in LOST.
- Flip check:
  - exp_flip toggles on every tick event.
  - In the cycle after a tick event, if flip_in != exp_flip, pulse err_flip on the next edge.
  - err_flip does not change state.
  - The flip check is skipped for the first tick after IDLE; instead, exp_flip is loaded with the inverse of its pre-tick value, sampled from flip_in.
- Error outputs:
  - All err_* outputs are registered. Each asserts exactly one cycle after its triggering cycle.
  - err_count adds the number of err_* pulses asserted in a cycle (0..2) and saturates at 255.
- locked is registered, equal to (state == LOCKED).

Decomposition:
- Shared package/include tick_mon_pkg:
  - State encoding localparams: IDLE=2'd0, SYNC=2'd1, LOCKED=2'd2, LOST=2'd3.
  - Default TICK_PERIOD and TOL constants, shared with the counter so both ends agree.
- One sub-module, gap_timer: a saturating PW-bit counter with clear and hold inputs, providing g and the in_window, early and timeout decodes.

Test Plan:
- Ticks every 100 cycles, flip toggling with each tick → locked=1 one cycle after the 2nd tick; period=100; no err_* pulses; tick_count wraps 15->0 on the 16th tick; err_count=0.
- While locked, tick gaps of 98 and then 102 → stays locked; period reads 98 then 102; no errors.
- While locked, tick gap of 97 → err_early pulses once, locked drops; the next tick returns to SYNC; the following in-window tick relocks; err_count=1.
- While locked, tick withheld → err_late pulses one cycle after gap cycle 102 (g=101); state LOST; a later tick moves to SYNC.
- While locked, flip_in not toggled after one tick → err_flip pulses once; locked stays 1; err_count increments by 1.
- Reset held 1 cycle while locked with tick_count=7 → next edge: all outputs 0, IDLE. A tick held high for 5 cycles then increments tick_count by exactly 1.

Source files
------------

// File: rtl/tick_mon_pkg.sv
// Shared definitions for the millisecond tick link: state codes, default timing
// and a saturating error-count helper.
package tick_mon_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SYNC   = 2'd1;
  localparam state_t LOCKED = 2'd2;
  localparam state_t LOST   = 2'd3;

  // The counter block uses these same defaults, so both ends of the link agree.
  localparam int unsigned DEF_TICK_PERIOD = 100;
  localparam int unsigned DEF_TOL         = 2;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Saturating inter-tick gap counter with window decodes on the interval g+1.
module gap_timer #(
  parameter int unsigned TICK_PERIOD = 100,
  parameter int unsigned TOL         = 2,
  parameter int unsigned PW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          hold_i,
  output logic [PW-1:0] interval_o,
  output logic          in_window_o,
  output logic          early_o,
  output logic          timeout_o
);

  localparam logic [PW-1:0] G_MAX  = '1;
  localparam logic [PW-1:0] ONE    = PW'(1);
  localparam logic [PW-1:0] WIN_LO = PW'(TICK_PERIOD - TOL);
  localparam logic [PW-1:0] WIN_HI = PW'(TICK_PERIOD + TOL);

  logic [PW-1:0] g_q;
  logic [PW-1:0] g_d;

  always_comb begin
    g_d = g_q;
    if (clear_i || hold_i) begin
      g_d = '0;
    end else if (g_q != G_MAX) begin
      g_d = g_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      g_q <= '0;
    end else begin
      g_q <= g_d;
    end
  end

  // Interval saturates with the counter instead of wrapping back into the window.
  assign interval_o  = (g_q == G_MAX) ? G_MAX : g_q + ONE;
  assign in_window_o = (interval_o >= WIN_LO) && (interval_o <= WIN_HI);
  assign early_o     = (interval_o < WIN_LO);
  assign timeout_o   = (interval_o == WIN_HI);

endmodule

// File: rtl/tick_monitor.sv
// Receive-side checker for the tick/flip link: measures tick spacing, tracks lock
// and raises registered early/late/flip error pulses with a saturating total.
module tick_monitor
  import tick_mon_pkg::*;
#(
  parameter int unsigned TICK_PERIOD = DEF_TICK_PERIOD,
  parameter int unsigned TOL         = DEF_TOL,
  parameter int unsigned PW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          flip_in,
  output logic [3:0]    tick_count,
  output logic [PW-1:0] period,
  output logic          locked,
  output logic          err_early,
  output logic          err_late,
  output logic          err_flip,
  output logic [7:0]    err_count
);

  logic          tick_q;
  logic          tick_ev;
  state_t        state_q, state_d;
  logic          exp_flip_q, exp_flip_d;
  logic          chk_q, chk_d;
  logic [3:0]    tick_count_q;
  logic [PW-1:0] period_q;
  logic          locked_q;
  logic          err_early_q, err_early_d;
  logic          err_late_q, err_late_d;
  logic          err_flip_q, err_flip_d;
  logic [7:0]    err_count_q;
  logic [1:0]    n_err;

  logic [PW-1:0] interval;
  logic          in_window;
  logic          early;
  logic          timeout;

  assign tick_ev = tick & ~tick_q;

  gap_timer #(
    .TICK_PERIOD(TICK_PERIOD),
    .TOL        (TOL),
    .PW         (PW)
  ) u_gap_timer (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (tick_ev),
    .hold_i     (state_d == IDLE),
    .interval_o (interval),
    .in_window_o(in_window),
    .early_o    (early),
    .timeout_o  (timeout)
  );

  always_comb begin
    state_d     = state_q;
    err_early_d = 1'b0;
    err_late_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick_ev) state_d = SYNC;
      end
      SYNC: begin
        if (tick_ev) begin
          if (in_window) state_d = LOCKED;
          else if (early) err_early_d = 1'b1;
        end else if (timeout) begin
          state_d    = IDLE;
          err_late_d = 1'b1;
        end
      end
      LOCKED: begin
        if (tick_ev) begin
          if (!in_window) begin
            state_d     = LOST;
            err_early_d = early;
          end
        end else if (timeout) begin
          state_d    = LOST;
          err_late_d = 1'b1;
        end
      end
      default: begin
        if (tick_ev) state_d = SYNC;
      end
    endcase
  end

  // The first tick out of IDLE seeds the expected flip level instead of checking it.
  always_comb begin
    exp_flip_d = exp_flip_q;
    if (tick_ev) begin
      exp_flip_d = (state_q == IDLE) ? flip_in : ~exp_flip_q;
    end
    chk_d      = tick_ev && (state_q != IDLE);
    err_flip_d = chk_q && (flip_in != exp_flip_q);
    n_err      = {1'b0, err_early_d} + {1'b0, err_late_d} + {1'b0, err_flip_d};
  end

  always_ff @(posedge clk) begin
    tick_q <= tick;
    if (reset) begin
      state_q      <= IDLE;
      exp_flip_q   <= flip_in;
      chk_q        <= 1'b0;
      tick_count_q <= 4'd0;
      period_q     <= '0;
      locked_q     <= 1'b0;
      err_early_q  <= 1'b0;
      err_late_q   <= 1'b0;
      err_flip_q   <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      exp_flip_q  <= exp_flip_d;
      chk_q       <= chk_d;
      locked_q    <= (state_d == LOCKED);
      err_early_q <= err_early_d;
      err_late_q  <= err_late_d;
      err_flip_q  <= err_flip_d;
      err_count_q <= sat_add8(err_count_q, n_err);
      if (tick_ev) begin
        tick_count_q <= tick_count_q + 4'd1;
        if (state_q != IDLE) period_q <= interval;
      end
    end
  end

  assign tick_count = tick_count_q;
  assign period     = period_q;
  assign locked     = locked_q;
  assign err_early  = err_early_q;
  assign err_late   = err_late_q;
  assign err_flip   = err_flip_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Randomised bench for tick_monitor: every cycle's outputs are compared against a
// cycle-indexed behavioural model of the tick link rules.
module tb_tick_monitor;
  import tick_mon_pkg::*;

  localparam int TP = DEF_TICK_PERIOD;
  localparam int TL = DEF_TOL;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic          flip_in;
  logic [3:0]    tick_count;
  logic [PW-1:0] period;
  logic          locked;
  logic          err_early;
  logic          err_late;
  logic          err_flip;
  logic [7:0]    err_count;

  tick_monitor #(
    .TICK_PERIOD(TP),
    .TOL        (TL),
    .PW         (PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .flip_in   (flip_in),
    .tick_count(tick_count),
    .period    (period),
    .locked    (locked),
    .err_early (err_early),
    .err_late  (err_late),
    .err_flip  (err_flip),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef enum int {M_IDLE, M_SYNC, M_LOCKED, M_LOST} mstate_t;
  mstate_t m_st = M_IDLE;
  longint  cyc = 0;
  longint  m_last = 0;
  bit      m_tprev = 1'b0;
  bit      m_exp = 1'b0;
  bit      m_chk = 1'b0;
  bit      m_ee = 1'b0, m_el = 1'b0, m_ef = 1'b0;
  int      m_cnt = 0, m_per = 0, m_errc = 0;

  bit flip_lvl = 1'b0;
  int prev_w   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_win(input longint p);
    return (p >= TP - TL) && (p <= TP + TL);
  endfunction

  // Model: interval is the cycle distance between tick rising edges.
  task automatic model_step(input bit t, input bit f, input bit rst);
    bit     ev;
    longint p;
    m_ee = 1'b0; m_el = 1'b0; m_ef = 1'b0;
    if (rst) begin
      m_st = M_IDLE; m_exp = f; m_chk = 1'b0;
      m_cnt = 0; m_per = 0; m_errc = 0;
    end else begin
      ev    = t && !m_tprev;
      m_ef  = m_chk && (f != m_exp);
      m_chk = ev && (m_st != M_IDLE);
      if (ev) begin
        p      = cyc - m_last;
        m_last = cyc;
        m_cnt  = (m_cnt + 1) % 16;
        if (m_st == M_IDLE) begin
          m_exp = f;
          m_st  = M_SYNC;
        end else begin
          m_exp = !m_exp;
          m_per = int'(p);
          case (m_st)
            M_SYNC:   if (in_win(p)) m_st = M_LOCKED; else m_ee = 1'b1;
            M_LOCKED: if (!in_win(p)) begin m_st = M_LOST; m_ee = 1'b1; end
            default:  m_st = M_SYNC;
          endcase
        end
      end else if ((m_st == M_SYNC || m_st == M_LOCKED) && (cyc - m_last == TP + TL)) begin
        m_el = 1'b1;
        m_st = (m_st == M_SYNC) ? M_IDLE : M_LOST;
      end
      m_errc = m_errc + int'(m_ee) + int'(m_el) + int'(m_ef);
      if (m_errc > 255) m_errc = 255;
    end
    m_tprev = t;
    cyc++;
  endtask

  task automatic cycle(input bit t, input bit f, input bit rst);
    tick = t; flip_in = f; reset = rst;
    model_step(t, f, rst);
    @(posedge clk); #1;
    check("locked",     {31'd0, locked},     {31'd0, m_st == M_LOCKED});
    check("tick_count", {28'd0, tick_count}, m_cnt);
    check("period",     {16'd0, period},     m_per);
    check("err_early",  {31'd0, err_early},  {31'd0, m_ee});
    check("err_late",   {31'd0, err_late},   {31'd0, m_el});
    check("err_flip",   {31'd0, err_flip},   {31'd0, m_ef});
    check("err_count",  {24'd0, err_count},  m_errc);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, flip_lvl, 1'b1);
    prev_w = 0;
    $display("[TB] reset %0d cycle(s)", n);
  endtask

  // Next rising edge lands 'gap' cycles after the previous one.
  task automatic tick_after(input int gap, input int w, input bit tog);
    for (int i = 0; i < gap - prev_w; i++) cycle(1'b0, flip_lvl, 1'b0);
    if (tog) flip_lvl = ~flip_lvl;
    for (int i = 0; i < w; i++) cycle(1'b1, flip_lvl, 1'b0);
    prev_w = w;
    $display("[TB] tick gap=%0d width=%0d toggle=%0b locked=%0b period=%0d tick_count=%0d err_count=%0d",
             gap, w, tog, locked, period, tick_count, err_count);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; flip_in = 1'b0;
    do_reset(2);
    check("rst_tick_count", {28'd0, tick_count}, 0);
    check("rst_locked",     {31'd0, locked},     0);

    // Nominal spacing, long enough to wrap tick_count.
    for (int i = 0; i < 18; i++) tick_after(100, 1, 1'b1);
    check("nominal_period", {16'd0, period}, 100);

    tick_after(98, 1, 1'b1);
    tick_after(102, 1, 1'b1);
    tick_after(97, 1, 1'b1);
    tick_after(100, 1, 1'b1);
    tick_after(100, 1, 1'b1);
    tick_after(100, 1, 1'b1);
    tick_after(120, 1, 1'b1);
    tick_after(100, 1, 1'b1);
    tick_after(100, 1, 1'b1);
    tick_after(100, 1, 1'b0);
    tick_after(100, 1, 1'b0);
    tick_after(100, 1, 1'b1);

    for (int i = 0; i < 150; i++) begin
      int sel, gap;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      gap = int'($urandom_range(60, 97));
      else if (sel == 1) gap = int'($urandom_range(103, 140));
      else               gap = int'($urandom_range(98, 102));
      tick_after(gap, int'($urandom_range(1, 3)), ($urandom_range(0, 9) != 0));
      if ($urandom_range(0, 49) == 0) do_reset(1);
    end

    // Rapid ticks keep the monitor in SYNC raising early errors until saturation.
    for (int i = 0; i < 300; i++)
      tick_after(int'($urandom_range(5, 20)), int'($urandom_range(1, 3)), $urandom_range(0, 1) != 0);
    for (int i = 0; i < 5; i++) cycle(1'b0, flip_lvl, 1'b0);
    check("err_count_sat", {24'd0, err_count}, 255);

    for (int i = 0; i < 40 && !(m_cnt == 7 && m_st == M_LOCKED); i++) tick_after(100, 1, 1'b1);
    check("pre_reset_count", {28'd0, tick_count}, 7);
    do_reset(1);
    check("post_reset_count",  {28'd0, tick_count}, 0);
    check("post_reset_locked", {31'd0, locked},     0);
    check("post_reset_errc",   {24'd0, err_count},  0);
    tick_after(50, 5, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, flip_lvl, 1'b0);
    check("held_tick_count", {28'd0, tick_count}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
